// File: rtl/clk_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_rec_pkg
// Purpose  : Shared FSM state encoding and NCO realign constant for the
//            bit clock recovery block.
// Revision : 1.0 - initial release
// ============================================================================
package clk_rec_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } clk_rec_state_e;

    // An edge in the first est>>c_realign_shift cycles of a half period
    // snaps the phase counter back to zero.
    localparam int unsigned c_realign_shift = 3;

endpackage
`default_nettype wire

// File: rtl/clk_rec_nco.sv
`default_nettype none
// ============================================================================
// Module   : clk_rec_nco
// Purpose  : Phase counter that toggles clk_rec at est/2 or est cycles, with
//            edge realignment and a phase-invert pulse.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rec_nco
    import clk_rec_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_300M,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] est,
    input  logic             half_mode,
    input  logic             sig_edge,
    input  logic             inv_pulse,
    input  logic             active,
    output logic             clk_rec
);

    logic [CNT_W-1:0] ph_q, ph_d;
    logic             clk_rec_q, clk_rec_d;
    logic [CNT_W:0]   w_tc;
    logic [CNT_W:0]   w_ph_inc;
    logic             w_realign;
    logic             w_toggle;

    always_comb begin
        w_tc      = half_mode ? {1'b0, est} : {2'b00, est[CNT_W-1:1]};
        w_ph_inc  = {1'b0, ph_q} + 1'b1;
        w_realign = sig_edge && (ph_q < (est >> c_realign_shift));
        w_toggle  = 1'b0;
        ph_d      = w_ph_inc[CNT_W-1:0];

        // Realign wins over a terminal count landing in the same cycle.
        if (w_realign) begin
            ph_d = '0;
        end else if (w_ph_inc >= w_tc) begin
            ph_d     = '0;
            w_toggle = 1'b1;
        end

        clk_rec_d = clk_rec_q ^ w_toggle ^ inv_pulse;

        if (!active) begin
            ph_d      = '0;
            clk_rec_d = 1'b0;
        end
    end

    always_ff @(posedge clk_300M) begin
        if (!rst_n) begin
            ph_q      <= '0;
            clk_rec_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            clk_rec_q <= clk_rec_d;
        end
    end

    assign clk_rec = clk_rec_q;

endmodule
`default_nettype wire

// File: rtl/bit_clk_recovery.sv
`default_nettype none
// ============================================================================
// Module   : bit_clk_recovery
// Purpose  : Recovers a bit clock from asynchronous NRZ data by tracking the
//            shortest high/low runs. Optional glitch filter enabled by
//            defining CLK_REC_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bit_clk_recovery
    import clk_rec_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int STABLE_W   = 12,
    parameter int LOCK_EDGES = 8,
    parameter int GLITCH_LEN = 2
) (
    input  logic             clk_300M,
    input  logic             rst_n,
    input  logic             signal,
    input  logic             half_mode,
    input  logic             inv_pulse,
    output logic             clk_rec,
    output logic [CNT_W-1:0] est_period,
    output logic             est_valid,
    output logic             locked
);

    localparam int LK_W = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0]    c_cnt_max    = '1;
    localparam logic [STABLE_W-1:0] c_stab_max   = '1;
    localparam logic [LK_W-1:0]     c_lock_edges = LK_W'(LOCK_EDGES);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    logic [CNT_W-1:0]     hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]     lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0]     min_hi_q, min_hi_d;
    logic [CNT_W-1:0]     min_lo_q, min_lo_d;
    logic [STABLE_W-1:0]  stab_q, stab_d;
    logic [CNT_W-1:0]     est_q, est_d;
    logic                 est_valid_q, est_valid_d;
    logic                 edge_dly_q, edge_dly_d;
    logic [LK_W-1:0]      lock_cnt_q, lock_cnt_d;
    clk_rec_state_e       state_q, state_d;

    logic                 w_lvl;
    logic                 w_edge;
    logic                 w_sat;
    logic [CNT_W-1:0]     w_run;
    logic [CNT_W-1:0]     w_min_sel;
    logic [CNT_W-1:0]     w_est_new;

`ifdef CLK_REC_GLITCH_FILTER_EN
    localparam int GL_W = $clog2(GLITCH_LEN + 1);
    localparam logic [GL_W-1:0] c_glitch_last = GL_W'(GLITCH_LEN - 1);

    logic            filt_q, filt_d;
    logic [GL_W-1:0] gcnt_q, gcnt_d;

    // The filtered level follows only after GLITCH_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (gcnt_q == c_glitch_last) begin
                filt_d = sync2_q;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_300M) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign w_lvl = filt_q;
`else
    if (GLITCH_LEN < 1) begin : g_glitch_len_unused
    end

    assign w_lvl = sync2_q;
`endif

    always_comb begin
        sync1_d = signal;
        sync2_d = sync1_q;
        prev_d  = w_lvl;

        w_edge    = w_lvl ^ prev_q;
        w_sat     = (hi_cnt_q == c_cnt_max) || (lo_cnt_q == c_cnt_max);
        w_run     = prev_q ? hi_cnt_q : lo_cnt_q;
        w_min_sel = prev_q ? min_hi_q : min_lo_q;

        // Run counters: the level's own counter counts, the ending run clears.
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (w_lvl) begin
            hi_cnt_d = (hi_cnt_q == c_cnt_max) ? hi_cnt_q : hi_cnt_q + 1'b1;
        end else begin
            lo_cnt_d = (lo_cnt_q == c_cnt_max) ? lo_cnt_q : lo_cnt_q + 1'b1;
        end
        if (w_edge) begin
            if (w_lvl) begin
                lo_cnt_d = '0;
            end else begin
                hi_cnt_d = '0;
            end
        end

        min_hi_d = min_hi_q;
        min_lo_d = min_lo_q;
        stab_d   = stab_q;
        if (w_sat) begin
            min_hi_d = c_cnt_max;
            min_lo_d = c_cnt_max;
            stab_d   = '0;
        end else if (w_edge) begin
            if (w_run < w_min_sel) begin
                if (prev_q) begin
                    min_hi_d = w_run;
                end else begin
                    min_lo_d = w_run;
                end
                stab_d = '0;
            end else if (stab_q == c_stab_max) begin
                // Slow upward decay lets the estimate recover from a too-short run.
                min_hi_d = (min_hi_q == c_cnt_max) ? min_hi_q : min_hi_q + 1'b1;
                min_lo_d = (min_lo_q == c_cnt_max) ? min_lo_q : min_lo_q + 1'b1;
                stab_d   = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end

        w_est_new   = CNT_W'(({1'b0, min_hi_q} + {1'b0, min_lo_q}) >> 1);
        edge_dly_d  = w_edge;
        est_d       = est_q;
        est_valid_d = 1'b0;
        if (edge_dly_q) begin
            est_d       = w_est_new;
            est_valid_d = (w_est_new != est_q);
        end

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (est_valid_q) begin
            lock_cnt_d = '0;
        end else if (w_edge && (lock_cnt_q != c_lock_edges)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end

        case (state_q)
            ACQUIRE: begin
                lock_cnt_d = '0;
                if ((min_hi_q != c_cnt_max) && (min_lo_q != c_cnt_max)) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!est_valid_q && (lock_cnt_q == c_lock_edges)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (est_valid_q) begin
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase

        if (w_sat) begin
            state_d    = ACQUIRE;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_300M) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            min_hi_q    <= c_cnt_max;
            min_lo_q    <= c_cnt_max;
            stab_q      <= '0;
            est_q       <= '0;
            est_valid_q <= 1'b0;
            edge_dly_q  <= 1'b0;
            lock_cnt_q  <= '0;
            state_q     <= ACQUIRE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            min_hi_q    <= min_hi_d;
            min_lo_q    <= min_lo_d;
            stab_q      <= stab_d;
            est_q       <= est_d;
            est_valid_q <= est_valid_d;
            edge_dly_q  <= edge_dly_d;
            lock_cnt_q  <= lock_cnt_d;
            state_q     <= state_d;
        end
    end

    clk_rec_nco #(
        .CNT_W (CNT_W)
    ) u_nco (
        .clk_300M  (clk_300M),
        .rst_n     (rst_n),
        .est       (est_q),
        .half_mode (half_mode),
        .sig_edge  (w_edge),
        .inv_pulse (inv_pulse),
        .active    (state_q != ACQUIRE),
        .clk_rec   (clk_rec)
    );

    assign est_period = est_q;
    assign est_valid  = est_valid_q;
    assign locked     = (state_q == LOCKED);

endmodule
`default_nettype wire
